// File: rtl/alu_multicycle.sv
// Multicycle execute unit: single-cycle base ops, iterative shift-add multiply and
// restoring divide, driven over a start/busy/done handshake.
module alu_multicycle #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SH = $clog2(XLEN);
    localparam int unsigned CW = SH + 1;
    localparam logic [CW-1:0]   LAST    = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ONE, S_MUL, S_DIV, S_FIN} state_e;

    typedef enum logic [4:0] {
        OP_SUM    = 5'd0,  OP_SLL  = 5'd1,  OP_SUB   = 5'd2,  OP_LOAD  = 5'd3,
        OP_XOR    = 5'd4,  OP_SRL  = 5'd5,  OP_NOT   = 5'd6,  OP_AND   = 5'd7,
        OP_SLA    = 5'd8,  OP_SRA  = 5'd9,  OP_LESS  = 5'd10, OP_OR    = 5'd11,
        OP_LESS_U = 5'd12, OP_MUL  = 5'd13, OP_MULH  = 5'd14, OP_MULHU = 5'd15,
        OP_DIV    = 5'd16, OP_DIVU = 5'd17, OP_REM   = 5'd18, OP_REMU  = 5'd19
    } op_e;

    state_e          st, st_next;
    logic [4:0]      op_r;
    logic [XLEN-1:0] a_r, b_r;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] acc_hi, acc_lo;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_r;

    // Accept-time classification from the raw inputs
    logic            in_mul, in_div, in_signed, div_special, take_mul, take_div;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        in_mul      = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
        in_div      = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        in_signed   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        div_special = in_div && ((b == '0) ||
                      (((op == OP_DIV) || (op == OP_REM)) && (a == MIN_INT) && (b == '1)));
        take_mul    = ENABLE_M && in_mul;
        take_div    = ENABLE_M && in_div && !div_special;
        mag_a       = (in_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
        mag_b       = (in_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_IDLE;
        else        st <= st_next;
    end

    always_comb begin
        st_next = st;
        case (st)
            S_IDLE: if (start) begin
                if (take_mul)      st_next = S_MUL;
                else if (take_div) st_next = S_DIV;
                else               st_next = S_ONE;
            end
            S_ONE:   st_next = S_FIN;
            S_MUL,
            S_DIV:   if (cnt == LAST) st_next = S_FIN;
            S_FIN:   st_next = S_IDLE;
            default: st_next = S_IDLE;
        endcase
    end

    assign busy = (st != S_IDLE);
    assign done = (st == S_FIN);

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mcand};
        div_diff  = div_shift[XLEN-1:0] - mcand;
        prod_s    = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
        quo_s     = neg_q ? (~acc_lo + 1'b1) : acc_lo;
        rem_s     = neg_r ? (~acc_hi + 1'b1) : acc_hi;
    end

    // Result selection for the edge entering FIN
    logic [SH-1:0]   shamt;
    logic [XLEN-1:0] one_result, mc_result, fin_result;
    logic            one_illegal, fin_illegal;

    always_comb begin
        shamt       = b_r[SH-1:0];
        one_result  = '0;
        one_illegal = 1'b0;
        case (op_r)
            OP_SUM:    one_result = a_r + b_r;
            OP_SLL,
            OP_SLA:    one_result = a_r << shamt;
            OP_SUB:    one_result = a_r - b_r;
            OP_LOAD:   one_result = b_r;
            OP_XOR:    one_result = a_r ^ b_r;
            OP_SRL:    one_result = a_r >> shamt;
            OP_NOT:    one_result = ~a_r;
            OP_AND:    one_result = a_r & b_r;
            OP_SRA:    one_result = $unsigned($signed(a_r) >>> shamt);
            OP_LESS:   one_result = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
            OP_OR:     one_result = a_r | b_r;
            OP_LESS_U: one_result = {{(XLEN-1){1'b0}}, (a_r < b_r)};
            OP_MUL, OP_MULH, OP_MULHU:
                       one_illegal = !ENABLE_M;
            OP_DIV, OP_DIVU: begin
                one_illegal = !ENABLE_M;
                if (ENABLE_M) one_result = (b_r == '0) ? '1 : MIN_INT;
            end
            OP_REM, OP_REMU: begin
                one_illegal = !ENABLE_M;
                if (ENABLE_M) one_result = (b_r == '0) ? a_r : '0;
            end
            default:   one_illegal = 1'b1;
        endcase

        case (op_r)
            OP_MUL:          mc_result = prod_s[XLEN-1:0];
            OP_MULH,
            OP_MULHU:        mc_result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: mc_result = quo_s;
            default:         mc_result = rem_s;
        endcase

        fin_result  = (st == S_ONE) ? one_result : mc_result;
        fin_illegal = (st == S_ONE) && one_illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
        end else begin
            case (st)
                S_IDLE: if (start) begin
                    op_r   <= op;
                    a_r    <= a;
                    b_r    <= b;
                    cnt    <= '0;
                    acc_hi <= '0;
                    // Multiply iterates over B with A as multiplicand; divide shifts A through
                    mcand  <= in_mul ? mag_a : mag_b;
                    acc_lo <= in_mul ? mag_b : mag_a;
                    neg_q  <= in_signed && (a[XLEN-1] ^ b[XLEN-1]);
                    neg_r  <= in_signed && a[XLEN-1];
                end
                S_MUL: if (cnt != LAST) begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                    cnt              <= cnt + 1'b1;
                end
                S_DIV: if (cnt != LAST) begin
                    acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
                    acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase

            if ((st_next == S_FIN) && (st != S_FIN)) begin
                result  <= fin_result;
                zero    <= (fin_result == '0);
                illegal <= fin_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (ENABLE_M=1 and ENABLE_M=0 instances).
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, zero, illegal;
    logic [31:0] result;
    logic        busy0, done0, zero0, illegal0;
    logic [31:0] result0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
    );

    alu_multicycle #(.XLEN(32), .ENABLE_M(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op(op), .a(a), .b(b),
        .busy(busy0), .done(done0), .result(result0), .zero(zero0), .illegal(illegal0)
    );

    // Issues one op on the selected instance and reports what was observed.
    task automatic do_op(input bit sel, input logic [4:0] o, input logic [31:0] va,
                         input logic [31:0] vb, output int edges, output logic [31:0] res,
                         output logic z, output logic ill, output bit busy_ok, output bit pulse_ok);
        logic d, bz;
        @(posedge clk); #1;
        op = o; a = va; b = vb;
        if (sel) start0 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start0 = 1'b0;
        op = '0; a = '0; b = '0;
        edges   = 1;
        busy_ok = 1'b1;
        d  = sel ? done0 : done;
        bz = sel ? busy0 : busy;
        if (!bz) busy_ok = 1'b0;
        while (!d && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            d  = sel ? done0 : done;
            bz = sel ? busy0 : busy;
            if (!bz) busy_ok = 1'b0;
        end
        res = sel ? result0 : result;
        z   = sel ? zero0 : zero;
        ill = sel ? illegal0 : illegal;
        @(posedge clk); #1;
        d = sel ? done0 : done;
        pulse_ok = !d && ((sel ? result0 : result) === res);
    endtask

    task automatic test_reset;
        int e; logic [31:0] r; logic z, il; bit bo, po;
        rst_n = 1'b0;
        #22;
        checks++;
        if ({busy, done, result, zero, illegal} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b result=%h zero=%b illegal=%b want 0 0 0 1 0",
                     busy, done, result, zero, illegal);
        end
        rst_n = 1'b1;
        do_op(1'b0, 5'd3, 32'h0, 32'h1234_5678, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'h1234_5678) begin
            errors++; $display("FAIL load_result got %h want 12345678", r);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            errors++; $display("FAIL async_reset result=%h zero=%b want 0 1", result, zero);
        end
        #3; rst_n = 1'b1;
    endtask

    task automatic test_sum;
        int e; logic [31:0] r; logic z, il; bit bo, po;
        do_op(1'b0, 5'd0, 32'hFFFF_FFFF, 32'h1, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'h0 || z !== 1'b1) begin
            errors++; $display("FAIL sum_wrap result=%h zero=%b want 0 1", r, z);
        end
        checks++;
        if (e !== 2) begin
            errors++; $display("FAIL sum_latency edges=%0d want 2", e);
        end
        checks++;
        if (po !== 1'b1) begin
            errors++; $display("FAIL sum_pulse_width got %b want 1", po);
        end
        do_op(1'b0, 5'd9, 32'h8000_0010, 32'h24, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'hF800_0001 || z !== 1'b0) begin
            errors++; $display("FAIL sra result=%h zero=%b want f8000001 0", r, z);
        end
        do_op(1'b0, 5'd10, 32'hFFFF_FFFE, 32'h1, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'h1) begin
            errors++; $display("FAIL less_signed result=%h want 1", r);
        end
        do_op(1'b0, 5'd12, 32'hFFFF_FFFE, 32'h1, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'h0) begin
            errors++; $display("FAIL less_unsigned result=%h want 0", r);
        end
    endtask

    task automatic test_mul;
        int e; logic [31:0] r; logic z, il; bit bo, po;
        do_op(1'b0, 5'd13, 32'hFFFF_FFFD, 32'h7, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mul result=%h want ffffffeb", r);
        end
        checks++;
        if (e !== 34 || bo !== 1'b1) begin
            errors++; $display("FAIL mul_latency edges=%0d busy_ok=%b want 34 1", e, bo);
        end
        do_op(1'b0, 5'd14, 32'hFFFF_FFFD, 32'h7, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL mulh result=%h want ffffffff", r);
        end
        do_op(1'b0, 5'd15, 32'hFFFF_FFFD, 32'h7, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'h0000_0006 || e !== 34) begin
            errors++; $display("FAIL mulhu result=%h edges=%0d want 00000006 34", r, e);
        end
    endtask

    task automatic test_div;
        int e; logic [31:0] r; logic z, il; bit bo, po;
        do_op(1'b0, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'h8000_0000 || e !== 2) begin
            errors++; $display("FAIL div_overflow result=%h edges=%0d want 80000000 2", r, e);
        end
        do_op(1'b0, 5'd18, 32'h8000_0000, 32'hFFFF_FFFF, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'h0 || z !== 1'b1 || e !== 2) begin
            errors++; $display("FAIL rem_overflow result=%h zero=%b edges=%0d want 0 1 2", r, z, e);
        end
        do_op(1'b0, 5'd17, 32'h7, 32'h0, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'hFFFF_FFFF || e !== 2) begin
            errors++; $display("FAIL divu_by_zero result=%h edges=%0d want ffffffff 2", r, e);
        end
        do_op(1'b0, 5'd19, 32'h7, 32'h0, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'h7 || e !== 2) begin
            errors++; $display("FAIL remu_by_zero result=%h edges=%0d want 00000007 2", r, e);
        end
        do_op(1'b0, 5'd16, 32'hFFFF_FFF9, 32'h2, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'hFFFF_FFFD || e !== 34) begin
            errors++; $display("FAIL div_signed result=%h edges=%0d want fffffffd 34", r, e);
        end
        do_op(1'b0, 5'd18, 32'hFFFF_FFF9, 32'h2, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL rem_signed result=%h want ffffffff", r);
        end
        do_op(1'b0, 5'd17, 32'd100, 32'd7, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'd14) begin
            errors++; $display("FAIL divu result=%0d want 14", r);
        end
    endtask

    task automatic test_ignore_start;
        int e;
        bit extra;
        @(posedge clk); #1;
        op = 5'd13; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; e = 1;
        repeat (4) begin @(posedge clk); #1; e++; end
        op = 5'd0; a = 32'h1; b = 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; e++;
        while (!done && e < 200) begin @(posedge clk); #1; e++; end
        checks++;
        if (result !== 32'd3000 || e !== 34) begin
            errors++; $display("FAIL start_ignored result=%0d edges=%0d want 3000 34", result, e);
        end
        extra = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (done) extra = 1'b1; end
        checks++;
        if (extra !== 1'b0) begin
            errors++; $display("FAIL no_queued_op extra_done=%b want 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int e; logic [31:0] r; logic z, il; bit bo, po;
        bit saw_done;
        @(posedge clk); #1;
        op = 5'd17; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL reset_mid_div busy=%b result=%h want 0 0", busy, result);
        end
        #4; rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_no_done saw=%b want 0", saw_done);
        end
        do_op(1'b0, 5'd0, 32'd2, 32'd3, e, r, z, il, bo, po);
        checks++;
        if (r !== 32'd5 || e !== 2) begin
            errors++; $display("FAIL after_reset_sum result=%0d edges=%0d want 5 2", r, e);
        end
    endtask

    task automatic test_illegal;
        int e; logic [31:0] r; logic z, il; bit bo, po;
        do_op(1'b0, 5'd25, 32'h55, 32'h66, e, r, z, il, bo, po);
        checks++;
        if (il !== 1'b1 || r !== 32'h0 || z !== 1'b1 || e !== 2) begin
            errors++; $display("FAIL illegal_op25 illegal=%b result=%h zero=%b edges=%0d want 1 0 1 2",
                               il, r, z, e);
        end
        do_op(1'b0, 5'd0, 32'h1, 32'h2, e, r, z, il, bo, po);
        checks++;
        if (il !== 1'b0 || r !== 32'h3) begin
            errors++; $display("FAIL illegal_clear illegal=%b result=%h want 0 3", il, r);
        end
        do_op(1'b1, 5'd13, 32'hFFFF_FFFD, 32'h7, e, r, z, il, bo, po);
        checks++;
        if (il !== 1'b1 || r !== 32'h0 || e !== 2) begin
            errors++; $display("FAIL nom_mul illegal=%b result=%h edges=%0d want 1 0 2", il, r, e);
        end
        do_op(1'b1, 5'd0, 32'h10, 32'h20, e, r, z, il, bo, po);
        checks++;
        if (il !== 1'b0 || r !== 32'h30) begin
            errors++; $display("FAIL nom_sum_clear illegal=%b result=%h want 0 30", il, r);
        end
    endtask

    initial begin
        test_reset;
        test_sum;
        test_mul;
        test_div;
        test_ignore_start;
        test_reset_mid;
        test_illegal;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
